// File: rtl/qrs_l3_pkg.sv
// qrs_l3_pkg
// Shared definitions for the level-3 QRS boundary detector:
//   - default window depths and coefficient width
//   - controller state encoding
//   - 16-bit sample index type
//   - saturating magnitude helper
package qrs_l3_pkg;

    localparam int QWIN_DEF = 16;
    localparam int SWIN_DEF = 24;
    localparam int DW_DEF   = 16;

    typedef logic [15:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // |x| with the most negative code folded onto the most positive one,
    // so the result always fits in DW_DEF bits.
    function automatic logic [DW_DEF-1:0] abs_sat(input logic signed [DW_DEF-1:0] x);
        logic [DW_DEF-1:0] m;
        if (x == {1'b1, {(DW_DEF-1){1'b0}}})
            m = {1'b0, {(DW_DEF-1){1'b1}}};
        else if (x < 0)
            m = DW_DEF'(-x);
        else
            m = DW_DEF'(x);
        return m;
    endfunction

endpackage

// File: rtl/qrs_l3_hist_buf.sv
// qrs_l3_hist_buf
// Circular history of level-3 coefficients, 2*QWIN entries deep.
//   clk, rst   : clock, async active-high reset
//   wr_en_i    : write wr_data_i at the write pointer, then advance
//   rd_addr_i  : read address; rd_data_o is registered (one-cycle latency)
//   wp_o       : slot the next sample will be written to
//   fill_o     : number of valid entries, saturating at 2*QWIN
module qrs_l3_hist_buf
    import qrs_l3_pkg::*;
#(
    parameter int QWIN = QWIN_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_i,
    input  logic [DW-1:0]                 wr_data_i,
    input  logic [$clog2(2*QWIN)-1:0]     rd_addr_i,
    output logic [DW-1:0]                 rd_data_o,
    output logic [$clog2(2*QWIN)-1:0]     wp_o,
    output logic [$clog2(2*QWIN):0]       fill_o
);

    localparam int AW    = $clog2(2*QWIN);
    localparam int FW    = AW + 1;
    localparam int DEPTH = 2*QWIN;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q;
    logic [FW-1:0] fill_q;
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i)
            mem_q[wp_q] <= wr_data_i;
    end

    // Depth is a power of two, so the pointer wraps on its own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q      <= '0;
            fill_q    <= '0;
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
            if (wr_en_i) begin
                wp_q <= wp_q + 1'b1;
                if (fill_q != FW'(DEPTH))
                    fill_q <= fill_q + 1'b1;
            end
        end
    end

    assign rd_data_o = rd_data_q;
    assign wp_o      = wp_q;
    assign fill_o    = fill_q;

endmodule

// File: rtl/qrs_boundary_l3_detect.sv
// qrs_boundary_l3_detect
// Finds the Q onset (last sub-threshold sample before R) and the S end
// (first sub-threshold sample after R) on the level-3 coefficient stream.
//   clk, rst                      : clock, async active-high reset
//   sample_in/sample_valid        : coefficient stream
//   r_peak_valid                  : current valid sample is the R peak
//   thr                           : unsigned magnitude threshold
//   q_begin_l3/s_end_l3           : boundary indices (held until next beat)
//   q_begin_l3_flag/s_end_l3_flag : sub-threshold boundary found
//   qwindow1_full/swindow1_full   : full pre-R history / full post-R window
//   busy, done, r_drop            : beat status, result strobe, ignored R
//
// state  | meaning
// IDLE   | waiting for an R peak
// ACTIVE | backward Q scan and forward S collection running
// DONE   | results registered, done pulse
module qrs_boundary_l3_detect
    import qrs_l3_pkg::*;
#(
    parameter int QWIN = QWIN_DEF,
    parameter int SWIN = SWIN_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] sample_in,
    input  logic                 sample_valid,
    input  logic                 r_peak_valid,
    input  logic [15:0]          thr,
    output logic [15:0]          q_begin_l3,
    output logic [15:0]          s_end_l3,
    output logic                 q_begin_l3_flag,
    output logic                 s_end_l3_flag,
    output logic                 qwindow1_full,
    output logic                 swindow1_full,
    output logic                 busy,
    output logic                 done,
    output logic                 r_drop
);

    localparam int KW = $clog2(2*QWIN);
    localparam int FW = KW + 1;
    localparam int JW = $clog2(SWIN+1);

    state_e         state_q;
    idx_t           idx_q, r_idx_q;
    logic [KW-1:0]  wp_l_q, k_q, pend_k_q, n_q;
    logic           qfull_q, pend_q, q_done_q, q_found_q;
    idx_t           q_idx_q;
    logic [JW-1:0]  j_q;
    logic           s_done_q, s_found_q;
    idx_t           s_idx_q;
    idx_t           q_out_q, s_out_q;
    logic           qf_out_q, sf_out_q, qw_out_q, sw_out_q;
    logic           busy_q, done_q, r_drop_q;

    logic [DW-1:0]  rd_data;
    logic [KW-1:0]  wp, rd_addr, n_start;
    logic [FW-1:0]  fill;
    logic           active, fill_ge, sample_low, rd_low;
    logic           q_issue, q_hit, q_last, q_fin, q_found_now, q_done_now;
    idx_t           q_idx_now;
    logic           s_take, s_hit, s_fin, s_found_now, s_done_now;
    logic [JW-1:0]  j_next;
    idx_t           s_idx_now;

    qrs_l3_hist_buf #(.QWIN(QWIN), .DW(DW)) u_hist (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (sample_valid),
        .wr_data_i (sample_in),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .wp_o      (wp),
        .fill_o    (fill)
    );

    // abs_sat never returns a value below 0, so thr == 0 is never "low".
    assign sample_low = abs_sat(sample_in) < thr;
    assign rd_low     = abs_sat($signed(rd_data)) < thr;

    assign active  = (state_q == ST_ACTIVE);
    assign fill_ge = fill >= FW'(QWIN);
    assign n_start = fill_ge ? KW'(QWIN) : KW'(fill);

    // Read for offset k is issued one cycle, evaluated the next.
    assign rd_addr     = wp_l_q - k_q;
    assign q_hit       = active & pend_q & rd_low;
    assign q_last      = active & pend_q & (pend_k_q == n_q);
    assign q_fin       = q_hit | q_last;
    assign q_issue     = active & ~q_done_q & (k_q <= n_q) & ~q_fin;
    assign q_idx_now   = q_hit ? (r_idx_q - idx_t'(pend_k_q)) : q_idx_q;
    assign q_found_now = q_found_q | q_hit;
    assign q_done_now  = q_done_q | q_fin;

    assign s_take      = active & sample_valid & ~s_done_q;
    assign j_next      = j_q + 1'b1;
    assign s_hit       = s_take & ~s_found_q & sample_low;
    assign s_fin       = s_take & (j_next == JW'(SWIN));
    assign s_idx_now   = s_hit ? (r_idx_q + idx_t'(j_next)) : s_idx_q;
    assign s_found_now = s_found_q | s_hit;
    assign s_done_now  = s_done_q | s_fin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            r_idx_q   <= '0;
            wp_l_q    <= '0;
            k_q       <= '0;
            pend_k_q  <= '0;
            n_q       <= '0;
            qfull_q   <= 1'b0;
            pend_q    <= 1'b0;
            q_done_q  <= 1'b0;
            q_found_q <= 1'b0;
            q_idx_q   <= '0;
            j_q       <= '0;
            s_done_q  <= 1'b0;
            s_found_q <= 1'b0;
            s_idx_q   <= '0;
            q_out_q   <= '0;
            s_out_q   <= '0;
            qf_out_q  <= 1'b0;
            sf_out_q  <= 1'b0;
            qw_out_q  <= 1'b0;
            sw_out_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            r_drop_q  <= 1'b0;
        end else begin
            if (sample_valid)
                idx_q <= idx_q + 1'b1;
            done_q   <= 1'b0;
            r_drop_q <= sample_valid & r_peak_valid & (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (sample_valid && r_peak_valid) begin
                        r_idx_q   <= idx_q;
                        wp_l_q    <= wp;
                        qfull_q   <= fill_ge;
                        n_q       <= n_start;
                        k_q       <= KW'(1);
                        pend_q    <= 1'b0;
                        q_done_q  <= (n_start == '0);
                        q_found_q <= 1'b0;
                        q_idx_q   <= idx_q - idx_t'(n_start);
                        j_q       <= '0;
                        s_done_q  <= 1'b0;
                        s_found_q <= 1'b0;
                        s_idx_q   <= idx_q + idx_t'(SWIN);
                        busy_q    <= 1'b1;
                        state_q   <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    pend_q <= q_issue;
                    if (q_issue) begin
                        k_q      <= k_q + 1'b1;
                        pend_k_q <= k_q;
                    end
                    if (q_fin) begin
                        q_done_q  <= 1'b1;
                        q_idx_q   <= q_idx_now;
                        q_found_q <= q_found_now;
                    end
                    if (s_take)
                        j_q <= j_next;
                    if (s_hit) begin
                        s_found_q <= 1'b1;
                        s_idx_q   <= s_idx_now;
                    end
                    if (s_fin)
                        s_done_q <= 1'b1;
                    if (q_done_now && s_done_now) begin
                        q_out_q  <= q_idx_now;
                        s_out_q  <= s_idx_now;
                        qf_out_q <= q_found_now;
                        sf_out_q <= s_found_now;
                        qw_out_q <= qfull_q;
                        sw_out_q <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign q_begin_l3      = q_out_q;
    assign s_end_l3        = s_out_q;
    assign q_begin_l3_flag = qf_out_q;
    assign s_end_l3_flag   = sf_out_q;
    assign qwindow1_full   = qw_out_q;
    assign swindow1_full   = sw_out_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign r_drop          = r_drop_q;

endmodule

// File: tb/tb_qrs_boundary_l3_detect.sv
// tb_qrs_boundary_l3_detect
// Table-driven beats, hand-written corner sequences and randomized beats,
// all checked against a history-based reference model of the detector.
module tb_qrs_boundary_l3_detect;
    import qrs_l3_pkg::*;

    localparam int QWIN = 16;
    localparam int SWIN = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] sample_in;
    logic               sample_valid, r_peak_valid;
    logic [15:0]        thr;
    logic [15:0]        q_begin_l3, s_end_l3;
    logic               q_begin_l3_flag, s_end_l3_flag, qwindow1_full, swindow1_full;
    logic               busy, done, r_drop;

    qrs_boundary_l3_detect #(.QWIN(QWIN), .SWIN(SWIN), .DW(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_in       (sample_in),
        .sample_valid    (sample_valid),
        .r_peak_valid    (r_peak_valid),
        .thr             (thr),
        .q_begin_l3      (q_begin_l3),
        .s_end_l3        (s_end_l3),
        .q_begin_l3_flag (q_begin_l3_flag),
        .s_end_l3_flag   (s_end_l3_flag),
        .qwindow1_full   (qwindow1_full),
        .swindow1_full   (swindow1_full),
        .busy            (busy),
        .done            (done),
        .r_drop          (r_drop)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: full sample history since reset plus beat bookkeeping.
    int hist[$];
    int m_total, edge_n, last_done;
    bit m_active, m_qfull, m_qfound, m_sfound;
    int m_r, m_qidx, m_qend_edge, m_sj, m_sidx;
    int e_q, e_s;
    bit e_qf, e_sf, e_qw, e_sw;
    bit exp_done, exp_drop, beat_seen;
    int drop_cnt;

    typedef struct {
        string nm;
        int    n_pre;
        int    low_at;
        int    low_val;
        int    pre_val;
        int    post_val;
        int    post_low_j;
        int    post_low_val;
        int    thr_v;
        bit    every;
        int    second_r;
        int    eq;
        int    es;
        bit    eqf;
        bit    esf;
        bit    eqw;
        int    edrops;
    } vec_t;

    vec_t vecs[6];

    function automatic bit m_low(int x, int t);
        int m;
        m = (x < 0) ? -x : x;
        if (m > 32767) m = 32767;
        return m < t;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(string tag);
        chk({tag, " q_begin_l3"}, int'(q_begin_l3), e_q);
        chk({tag, " s_end_l3"}, int'(s_end_l3), e_s);
        chk({tag, " q_flag"}, int'(q_begin_l3_flag), int'(e_qf));
        chk({tag, " s_flag"}, int'(s_end_l3_flag), int'(e_sf));
        chk({tag, " qwindow1_full"}, int'(qwindow1_full), int'(e_qw));
        chk({tag, " swindow1_full"}, int'(swindow1_full), int'(e_sw));
    endtask

    task automatic model_reset();
        hist.delete();
        m_total   = 0;
        m_active  = 0;
        last_done = -10;
        e_q = 0; e_s = 0; e_qf = 0; e_sf = 0; e_qw = 0; e_sw = 0;
    endtask

    // Apply one cycle of input (called at a negedge), update the model for
    // the coming posedge, then check at the following negedge.
    task automatic step(bit v, int x, bit rp, bit full_chk);
        bit started;
        int kend;
        sample_valid = v;
        sample_in    = 16'(x);
        r_peak_valid = rp;
        @(posedge clk);
        edge_n++;
        exp_done = 0;
        exp_drop = 0;
        started  = 0;
        if (v) begin
            if (rp) begin
                if (m_active || last_done == edge_n - 1) begin
                    exp_drop = 1;
                end else begin
                    m_r      = m_total;
                    m_qfull  = (m_total >= QWIN);
                    kend     = m_qfull ? QWIN : m_total;
                    m_qfound = 0;
                    m_qidx   = m_r - kend;
                    for (int k = 1; k <= (m_qfull ? QWIN : m_total); k++) begin
                        if (!m_qfound && m_low(hist[m_total-k], int'(thr))) begin
                            m_qfound = 1;
                            m_qidx   = m_r - k;
                            kend     = k;
                        end
                    end
                    m_qend_edge = edge_n + kend + 1;
                    m_sj     = 0;
                    m_sfound = 0;
                    m_sidx   = m_r + SWIN;
                    m_active = 1;
                    started  = 1;
                end
            end
            if (m_active && !started && m_sj < SWIN) begin
                m_sj++;
                if (!m_sfound && m_low(x, int'(thr))) begin
                    m_sfound = 1;
                    m_sidx   = m_r + m_sj;
                end
            end
            hist.push_back(x);
            m_total++;
        end
        if (m_active && m_sj == SWIN && edge_n >= m_qend_edge) begin
            exp_done  = 1;
            m_active  = 0;
            last_done = edge_n;
            e_q  = m_qidx & 16'hFFFF;
            e_s  = m_sidx & 16'hFFFF;
            e_qf = m_qfound;
            e_sf = m_sfound;
            e_qw = m_qfull;
            e_sw = 1;
        end
        @(negedge clk);
        if (done || exp_done) beat_seen = 1;
        if (r_drop) drop_cnt++;
        chk("done", int'(done), int'(exp_done));
        chk("r_drop", int'(r_drop), int'(exp_drop));
        chk("busy", int'(busy), int'(m_active || last_done == edge_n));
        if (full_chk || exp_done || done) chk_outputs("out");
    endtask

    task automatic do_reset();
        sample_valid = 0;
        r_peak_valid = 0;
        sample_in    = '0;
        rst          = 1;
        repeat (2) @(negedge clk);
        model_reset();
        chk_outputs("reset");
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset r_drop", int'(r_drop), 0);
        rst = 0;
    endtask

    task automatic feed_until_done(int post_low_j, int post_low_val, int post_val,
                                   int second_r, bit every, bit rnd);
        int j;
        bit rp;
        int val;
        j = 0;
        beat_seen = 0;
        for (int c = 0; c < 300 && !beat_seen; c++) begin
            j++;
            if (rnd) begin
                val = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 200)) - 100
                                                  : int'($urandom_range(0, 4000)) - 2000;
                rp  = ($urandom_range(0, 7) == 0);
            end else begin
                val = (j == post_low_j) ? post_low_val : post_val;
                rp  = (j == second_r);
            end
            step(1, val, rp, 1);
            if (!beat_seen && (!every || (rnd && $urandom_range(0, 1) == 1)))
                step(0, 0, 0, 1);
        end
        if (!beat_seen) chk("beat_timeout", 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
    endtask

    task automatic run_vec(vec_t v);
        do_reset();
        thr = 16'(v.thr_v);
        drop_cnt = 0;
        for (int i = 0; i < v.n_pre; i++) begin
            step(1, (i == v.low_at) ? v.low_val : v.pre_val, 0, 1);
            if (!v.every) step(0, 0, 0, 1);
        end
        step(1, 1000, 1, 1);
        if (!v.every) step(0, 0, 0, 1);
        feed_until_done(v.post_low_j, v.post_low_val, v.post_val, v.second_r, v.every, 0);
        chk({v.nm, " q_begin_l3"}, int'(q_begin_l3), v.eq);
        chk({v.nm, " s_end_l3"}, int'(s_end_l3), v.es);
        chk({v.nm, " q_flag"}, int'(q_begin_l3_flag), int'(v.eqf));
        chk({v.nm, " s_flag"}, int'(s_end_l3_flag), int'(v.esf));
        chk({v.nm, " qwindow1_full"}, int'(qwindow1_full), int'(v.eqw));
        chk({v.nm, " swindow1_full"}, int'(swindow1_full), 1);
        chk({v.nm, " r_drop count"}, drop_cnt, v.edrops);
    endtask

    initial begin
        rst = 1; sample_valid = 0; r_peak_valid = 0; sample_in = '0; thr = 16'd100;
        edge_n = 0;
        model_reset();

        //       nm        pre lowat lowv  prev   postv pj  pjv  thr  ev 2ndR  eq     es  qf sf qw drops
        vecs[0] = '{"peaks",  35, 30,   50,   500,   500, 7,  -20, 100, 0, 0,   30,    42, 1, 1, 1, 0};
        vecs[1] = '{"flat",   35, -1,   0,    500,   500, 0,  0,   100, 0, 0,   19,    59, 0, 0, 1, 0};
        vecs[2] = '{"short",  5,  2,    0,    500,   500, 0,  0,   100, 0, 0,   2,     29, 1, 0, 0, 0};
        vecs[3] = '{"race",   30, 14,   10,   500,   500, 0,  0,   100, 1, 3,   14,    54, 1, 0, 1, 1};
        vecs[4] = '{"negsat", 40, -1,   0,  -32768,  500, 0,  0,   100, 0, 0,   24,    64, 0, 0, 1, 0};
        vecs[5] = '{"thr0",   20, -1,   0,    0,     0,   0,  0,   0,   1, 0,   4,     44, 0, 0, 1, 0};

        // Asynchronous reset in the middle of a beat.
        do_reset();
        thr = 16'd100;
        for (int i = 0; i < 10; i++) step(1, 500, 0, 1);
        step(1, 1000, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 500, 0, 1);
        #1 rst = 1;
        #1;
        chk("async_rst busy", int'(busy), 0);
        chk("async_rst done", int'(done), 0);
        model_reset();
        chk_outputs("async_rst");
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) step(1, 500, 0, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Index counter wrap: R at index 65530, S end lands past 65535.
        do_reset();
        thr = 16'd100;
        for (int i = 0; i < 65514; i++) step(1, 500, 0, 0);
        for (int i = 0; i < 16; i++) step(1, -32768, 0, 0);
        step(1, 1000, 1, 1);
        feed_until_done(10, -5, 500, 0, 1, 0);
        chk("wrap q_begin_l3", int'(q_begin_l3), 65514);
        chk("wrap s_end_l3", int'(s_end_l3), 4);
        chk("wrap q_flag", int'(q_begin_l3_flag), 0);
        chk("wrap s_flag", int'(s_end_l3_flag), 1);

        // Randomized beats back to back, no reset in between.
        do_reset();
        for (int b = 0; b < 16; b++) begin
            int npre;
            thr  = 16'($urandom_range(0, 300));
            npre = $urandom_range(0, 40);
            for (int i = 0; i < npre; i++) begin
                int val;
                case ($urandom_range(0, 5))
                    0: val = -32768;
                    1: val = int'($urandom_range(0, 200)) - 100;
                    default: val = int'($urandom_range(0, 4000)) - 2000;
                endcase
                step(1, val, 0, 1);
                if ($urandom_range(0, 2) == 0) step(0, 0, 0, 1);
            end
            step(1, 1000, 1, 1);
            feed_until_done(0, 0, 0, 0, 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
